// File: rtl/blram_dp.sv
// True-dual-port synchronous block RAM with selectable read-during-write mode,
// optional output register and an optional post-reset zeroing sequence.
module blram_dp #(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int DEPTH        = 2**AW,
    parameter int OUT_REG      = 0,
    parameter int WR_MODE      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          collision
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t        RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
    localparam logic          RST_BUSY  = (CLEAR_ON_RST != 0);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          init_busy_q, init_busy_d;
    logic          coll_q, coll_d;

    // Stage 1 holds the latency-1 read result; stage 2 is the optional extra register.
    logic [DW-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [DW-1:0] b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic          a_v_q, a_v_d, b_v_q, b_v_d;

    logic          run, clearing;
    logic          a_ok, b_ok, same_addr;
    logic          a_wr, b_wr, b_wr_eff;
    logic [DW-1:0] a_rd, b_rd, b_new;
    logic          mem_a_we;
    logic [AW-1:0] mem_a_addr;
    logic [DW-1:0] mem_a_data;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    assign run      = (state_q == ST_RUN);
    assign clearing = (state_q == ST_CLEAR);

    always_comb begin
        a_ok      = in_range(a_addr);
        b_ok      = in_range(b_addr);
        same_addr = (a_addr == b_addr);
        a_rd      = a_ok ? mem[a_addr] : '0;
        b_rd      = b_ok ? mem[b_addr] : '0;
        a_wr      = run && a_en && a_we && a_ok;
        b_wr      = run && b_en && b_we && b_ok;
        // Port A wins a same-address write; port B's data is dropped.
        b_wr_eff  = b_wr && !(a_wr && same_addr);
        b_new     = (a_wr && same_addr) ? a_din : b_din;
        coll_d    = a_wr && b_wr && same_addr;
    end

    // The clear sequence borrows port A's write path.
    always_comb begin
        mem_a_we   = a_wr;
        mem_a_addr = a_addr;
        mem_a_data = a_din;
        if (clearing) begin
            mem_a_we   = 1'b1;
            mem_a_addr = clr_cnt_q;
            mem_a_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_a_we) begin
            mem[mem_a_addr] <= mem_a_data;
        end
        if (b_wr_eff) begin
            mem[b_addr] <= b_din;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_busy_d = init_busy_q;
        if (clearing) begin
            if (clr_cnt_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_busy_d = 1'b0;
                clr_cnt_d   = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + AW'(1);
            end
        end
    end

    always_comb begin
        a_s1_d = a_s1_q;
        b_s1_d = b_s1_q;
        a_v_d  = run && a_en;
        b_v_d  = run && b_en;
        if (run && a_en) begin
            if (a_we && (WR_MODE != 0)) begin
                a_s1_d = a_ok ? a_din : '0;
            end else begin
                a_s1_d = a_rd;
            end
        end
        if (run && b_en) begin
            if (b_we && (WR_MODE != 0)) begin
                b_s1_d = b_ok ? b_new : '0;
            end else begin
                b_s1_d = b_rd;
            end
        end
        a_s2_d = a_v_q ? a_s1_q : a_s2_q;
        b_s2_d = b_v_q ? b_s1_q : b_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            init_busy_q <= RST_BUSY;
            coll_q      <= 1'b0;
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            b_s1_q      <= '0;
            b_s2_q      <= '0;
            a_v_q       <= 1'b0;
            b_v_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_busy_q <= init_busy_d;
            coll_q      <= coll_d;
            a_s1_q      <= a_s1_d;
            a_s2_q      <= a_s2_d;
            b_s1_q      <= b_s1_d;
            b_s2_q      <= b_s2_d;
            a_v_q       <= a_v_d;
            b_v_q       <= b_v_d;
        end
    end

    assign init_busy = init_busy_q;
    assign collision = coll_q;
    assign a_dout    = (OUT_REG != 0) ? a_s2_q : a_s1_q;
    assign b_dout    = (OUT_REG != 0) ? b_s2_q : b_s1_q;

endmodule

// File: tb/tb_blram_dp.sv
// Bench for blram_dp: two instances (latency 1 read-first, latency 2 write-first)
// share the same stimulus and are checked against one reference model.
module tb_blram_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic        init_busy0, init_busy1, collision0, collision1;
    logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] mem_m [32];
    logic [15:0] ea0, eb0, ea1, eb1, pa, pb;
    logic        pa_v, pb_v, coll_m;

    always #5 clk = ~clk;

    blram_dp #(.DW(16), .AW(5), .DEPTH(16), .OUT_REG(0), .WR_MODE(0), .CLEAR_ON_RST(1)) u_dut0 (
        .clk(clk), .rst(rst), .init_busy(init_busy0),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0),
        .collision(collision0)
    );

    blram_dp #(.DW(16), .AW(5), .DEPTH(16), .OUT_REG(1), .WR_MODE(1), .CLEAR_ON_RST(1)) u_dut1 (
        .clk(clk), .rst(rst), .init_busy(init_busy1),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1),
        .collision(collision1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input bit zero_mem);
        ea0 = '0; eb0 = '0; ea1 = '0; eb1 = '0;
        pa = '0; pb = '0; pa_v = 1'b0; pb_v = 1'b0; coll_m = 1'b0;
        if (zero_mem) begin
            for (int i = 0; i < 32; i++) mem_m[i] = '0;
        end
    endtask

    task automatic drive_idle();
        a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    endtask

    task automatic drive_random();
        a_en = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        a_addr = 5'($urandom_range(0, 31)); a_din = 16'($urandom);
        b_en = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        b_addr = 5'($urandom_range(0, 31)); b_din = 16'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_a0"}, 32'(a_dout0), 0);
        check({tag, "_b0"}, 32'(b_dout0), 0);
        check({tag, "_a1"}, 32'(a_dout1), 0);
        check({tag, "_b1"}, 32'(b_dout1), 0);
        check({tag, "_coll0"}, 32'(collision0), 0);
        check({tag, "_coll1"}, 32'(collision1), 0);
    endtask

    // Runs clear cycles with random port traffic until init_busy drops or limit is hit.
    task automatic watch_clear(input int limit, output int n);
        n = 0;
        while (init_busy0 === 1'b1 && n < limit) begin
            drive_random();
            @(posedge clk);
            @(negedge clk);
            n++;
            check("clr_busy0", 32'(init_busy0), (n < 16) ? 1 : 0);
            check("clr_busy1", 32'(init_busy1), (n < 16) ? 1 : 0);
            check_quiet("clr");
        end
        drive_idle();
    endtask

    // One RUN cycle: apply inputs, advance the model at the edge, compare after.
    task automatic cycle(input logic aen, input logic awe, input logic [4:0] aa, input logic [15:0] ad,
                         input logic ben, input logic bwe, input logic [4:0] ba, input logic [15:0] bd);
        logic [15:0] ra, rb, a_new, b_new;
        logic aw, bw;
        a_en = aen; a_we = awe; a_addr = aa; a_din = ad;
        b_en = ben; b_we = bwe; b_addr = ba; b_din = bd;
        @(posedge clk);
        aw = aen && awe && (aa < 16);
        bw = ben && bwe && (ba < 16);
        ra = (aa < 16) ? mem_m[aa] : 16'h0;
        rb = (ba < 16) ? mem_m[ba] : 16'h0;
        a_new = (aen && awe) ? ((aa < 16) ? ad : 16'h0) : ra;
        b_new = (ben && bwe) ? ((ba < 16) ? ((aw && aa == ba) ? ad : bd) : 16'h0) : rb;
        coll_m = aw && bw && (aa == ba);
        if (bw) mem_m[ba] = bd;
        if (aw) mem_m[aa] = ad;
        if (aen) ea0 = ra;
        if (ben) eb0 = rb;
        if (pa_v) ea1 = pa;
        if (pb_v) eb1 = pb;
        pa_v = aen; pb_v = ben;
        if (aen) pa = a_new;
        if (ben) pb = b_new;
        @(negedge clk);
        check("a_dout0", 32'(a_dout0), 32'(ea0));
        check("b_dout0", 32'(b_dout0), 32'(eb0));
        check("a_dout1", 32'(a_dout1), 32'(ea1));
        check("b_dout1", 32'(b_dout1), 32'(eb1));
        check("coll0", 32'(collision0), 32'(coll_m));
        check("coll1", 32'(collision1), 32'(coll_m));
        check("busy0", 32'(init_busy0), 0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    endtask

    initial begin
        int n;
        drive_idle();
        rst = 1'b1;
        model_reset(1'b1);
        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(init_busy0), 1);
        check("rst_busy1", 32'(init_busy1), 1);
        check_quiet("rst");

        // clear aborted after 6 cycles by a 2-cycle reset
        rst = 1'b0;
        watch_clear(6, n);
        check("mid_cycles", n, 6);
        check("mid_busy", 32'(init_busy0), 1);
        rst = 1'b1;
        repeat (2) begin
            drive_random();
            @(posedge clk);
            @(negedge clk);
            check("rst2_busy0", 32'(init_busy0), 1);
            check_quiet("rst2");
        end
        rst = 1'b0;
        watch_clear(200, n);
        check("clear_len", n, 16);
        check("busy1_done", 32'(init_busy1), 0);
        model_reset(1'b1);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 5'(i), 16'($urandom), 1'b1, 1'b0, 5'(15 - i), 16'($urandom));
        end
        idle_cycle();

        // basic write then cross-port read
        cycle(1'b1, 1'b1, 5'd5, 16'h1234, 1'b0, 1'b0, 5'd0, 16'h0);
        cycle(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd5, 16'h0);
        check("basic_b0", 32'(b_dout0), 32'h1234);
        idle_cycle();
        check("basic_b1", 32'(b_dout1), 32'h1234);

        // same-port read during write
        cycle(1'b1, 1'b1, 5'd3, 16'h00AA, 1'b0, 1'b0, 5'd0, 16'h0);
        cycle(1'b1, 1'b1, 5'd3, 16'h00BB, 1'b0, 1'b0, 5'd0, 16'h0);
        check("rdw_a0", 32'(a_dout0), 32'h00AA);
        idle_cycle();
        check("rdw_a1", 32'(a_dout1), 32'h00BB);

        // write collision
        cycle(1'b1, 1'b1, 5'd7, 16'h1111, 1'b1, 1'b1, 5'd7, 16'h2222);
        check("coll_hi0", 32'(collision0), 1);
        check("coll_hi1", 32'(collision1), 1);
        cycle(1'b1, 1'b0, 5'd7, 16'h0, 1'b1, 1'b0, 5'd7, 16'h0);
        check("coll_lo0", 32'(collision0), 0);
        check("coll_rd_a", 32'(a_dout0), 32'h1111);
        check("coll_rd_b", 32'(b_dout0), 32'h1111);

        // cross-port read while writing
        cycle(1'b1, 1'b1, 5'd9, 16'h0F0F, 1'b0, 1'b0, 5'd0, 16'h0);
        cycle(1'b1, 1'b1, 5'd9, 16'hF0F0, 1'b1, 1'b0, 5'd9, 16'h0);
        check("xrd_old", 32'(b_dout0), 32'h0F0F);
        cycle(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd9, 16'h0);
        check("xrd_new", 32'(b_dout0), 32'hF0F0);

        // out-of-range accesses
        cycle(1'b1, 1'b1, 5'd20, 16'hABCD, 1'b1, 1'b1, 5'd20, 16'h5555);
        check("oor_coll", 32'(collision0), 0);
        cycle(1'b1, 1'b0, 5'd20, 16'h0, 1'b1, 1'b0, 5'd4, 16'h0);
        check("oor_rd", 32'(a_dout0), 0);
        check("oor_alias", 32'(b_dout0), 0);

        // random traffic over a narrow address window to provoke conflicts
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 16'($urandom));
        end

        // reset while running, then the array must be zeroed again
        rst = 1'b1;
        @(negedge clk);
        check("rrst_busy", 32'(init_busy0), 1);
        check_quiet("rrst");
        rst = 1'b0;
        watch_clear(200, n);
        check("clear_len2", n, 16);
        model_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 5'(15 - i), 16'h0, 1'b1, 1'b0, 5'(i), 16'h0);
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blram_dp.md
# blram_dp

Parametrised true-dual-port synchronous block RAM, the successor to the single-port program/data RAM used by TinyMIPS. It provides configurable data width, address width and depth, two independent read/write ports, and selectable same-port read-during-write behaviour. It also offers an optional extra output register and an optional hardware clear sequence after reset. Port A serves the core's data path; port B serves instruction fetch or a debug/loader agent.

## Interface
- DW, 16, data width in bits
- AW, 8, address width in bits
- DEPTH, 2**AW, number of words; must be at most 2**AW
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = read latency 2 cycles through an extra output register
- WR_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RST, 1, 1 = zero the whole array after reset deassertion; 0 = array untouched

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- init_busy  out  1  high while the clear sequence runs
- a_en  in  1  port A access enable
- a_we  in  1  port A write enable; qualified by a_en
- a_addr  in  AW  port A word address
- a_din  in  DW  port A write data
- a_dout  out  DW  port A read data
- b_en, b_we, b_addr, b_din, b_dout  same widths and meanings as port A, for port B
- collision  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- States: CLEAR and RUN. rst asserted forces CLEAR when CLEAR_ON_RST=1, otherwise RUN.
- CLEAR: an internal counter starts at 0 on the first edge after rst falls and writes 0 to one address per cycle, from 0 to DEPTH-1. After the DEPTH-1 write, the block moves to RUN. init_busy=1 for exactly DEPTH cycles. Port inputs are ignored and a_dout/b_dout hold 0.
- rst asserted mid-clear aborts the sequence. The counter restarts at 0 after release.
- RUN: a port with en=1 and we=0 reads mem[addr]. A port with en=1 and we=1 writes din to mem[addr]; its dout follows WR_MODE.
- en=0: that port's dout holds its last value. No array access.
- Cross-port read and write to the same address in the same cycle: the reader gets the old data, independent of WR_MODE.
- Both ports write the same address in the same cycle: port A's data is stored, port B's is dropped, and collision pulses high on the next cycle.
- Address >= DEPTH (possible only when DEPTH < 2**AW): writes are ignored and reads return 0. Such an access never raises collision.
- Async reset clears a_dout, b_dout, the output-register stage, collision, the clear counter and the state. The array itself is zeroed only by the CLEAR sequence.

## Timing
- Reset values: a_dout=0, b_dout=0, collision=0. init_busy=1 if CLEAR_ON_RST=1, else 0.
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), measured from the edge that samples en and addr to the edge at which dout is valid.
- Write: the array is updated at the sampling edge. A read of that address issued on the next cycle returns the new data.
- OUT_REG=1: the second stage loads only if its first stage was enabled on the previous cycle. Otherwise it holds.
- collision is asserted for the cycle after the conflicting edge, aligned with OUT_REG=0 read data, regardless of OUT_REG.
- Full-throughput: both ports accept one access per cycle each, every cycle, with no stalls.

## Test plan
- Reset clear: DEPTH=16, CLEAR_ON_RST=1; release rst -> init_busy high for exactly 16 cycles; then reads of addresses 0..15 on both ports return 0x0000.
- Basic R/W: A writes 0x1234 to addr 5; next cycle B reads addr 5 -> b_dout=0x1234 one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1).
- Same-port read-during-write: mem[3]=0x00AA; A writes 0x00BB to addr 3 -> a_dout=0x00AA with WR_MODE=0, 0x00BB with WR_MODE=1.
- Write collision: A writes 0x1111 and B writes 0x2222 to addr 7 in the same cycle -> collision pulses for one cycle; a subsequent read of addr 7 returns 0x1111.
- Cross-port read/write: mem[9]=0x0F0F; A writes 0xF0F0 to addr 9 while B reads addr 9 -> b_dout=0x0F0F; B re-reads next cycle -> 0xF0F0.
- Reset mid-clear: assert rst at clear cycle 6 for 2 cycles -> init_busy stays 1, the counter restarts, and init_busy falls exactly DEPTH cycles after the second release; any port access during CLEAR leaves douts at 0.
